// File: rtl/frequency_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frequency_controller_pkg
//  Description : Shared constants for the lock-in reference frequency
//                controller: default frequency, step table, seven-segment
//                codes and scale-index width.
//  Revision    : 1.0  initial release
// ============================================================================
package frequency_controller_pkg;

   localparam int DEFAULT_FREQ = 1000;
   localparam int SCALE_W      = 2;
   localparam int STEP_W       = 14;

   typedef logic [SCALE_W-1:0] scale_idx_t;

   // Active-low segment codes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Step table indexed by the scale index: 1 / 10 / 100 / 1000
   function automatic logic [STEP_W-1:0] step_value(input scale_idx_t idx);
      logic [STEP_W-1:0] s;
      case (idx)
         2'd0:    s = 14'd1;
         2'd1:    s = 14'd10;
         2'd2:    s = 14'd100;
         default: s = 14'd1000;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_decoder
//  Description : 4-bit decimal digit to active-low seven-segment pattern.
//                Codes above 9 blank the display.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_decoder
   import frequency_controller_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Digit lookup; anything outside 0..9 is shown blank
   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/frequency_controller_top.sv
`default_nettype none
// ============================================================================
//  Module      : frequency_controller_top
//  Description : Pushbutton-driven reference frequency setting for the
//                lock-in analyzer, with saturating inc/dec, selectable step
//                and a decimal seven-segment readout.
//  Revision    : 1.0  initial release
// ============================================================================
module frequency_controller_top
   import frequency_controller_pkg::*;
#(
   parameter int FREQUENCY_RANGE = 8192,
   parameter int W               = 13
)(
   input  logic         clk,
   input  logic         key_0,
   input  logic         key_1,
   input  logic         key_2,
   input  logic         key_3,
   output logic         reset_active,
   output logic [W-1:0] frequency_out,
   output logic [6:0]   HEX0,
   output logic [6:0]   HEX1,
   output logic [6:0]   HEX2,
   output logic [6:0]   HEX3,
   output logic [6:0]   HEX4,
   output logic [6:0]   HEX5,
   output logic [6:0]   HEX6,
   output logic [6:0]   HEX7
);

   localparam int              AW      = W + 1;
   localparam logic [AW-1:0]   MAX_EXT = AW'(FREQUENCY_RANGE - 1);

   logic             rst_meta_q;
   logic [3:1]       key_raw;
   logic [3:1]       press;
   logic [W-1:0]     freq_q, freq_d;
   scale_idx_t       scale_q, scale_d;
   logic [AW-1:0]    freq_ext, step_ext, sum_ext, diff_ext;
   logic [13:0]      fbin;
   logic [3:0]       digit [5];
   logic [6:0]       seg   [5];

   // Two-stage synchroniser for key_0; second stage stores the inverted level
   always_ff @(posedge clk) begin
      rst_meta_q   <= key_0;
      reset_active <= ~rst_meta_q;
   end

   assign key_raw = {key_3, key_2, key_1};

   // Per-key synchroniser and falling-edge detector. The history register
   // simply follows the synchronised level, including during reset, so a
   // key held through reset release is already seen as pressed and does not
   // fire until it is released and pressed again.
   for (genvar k = 1; k <= 3; k++) begin : g_key
      logic sync1_q, sync2_q, hist_q;

      // Synchronise the raw button and keep one cycle of history
      always_ff @(posedge clk) begin
         sync1_q <= key_raw[k];
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end

      assign press[k] = hist_q & ~sync2_q;
   end

   // Arithmetic is one bit wider than the register so neither direction wraps
   assign freq_ext = {1'b0, freq_q};
   assign step_ext = AW'(step_value(scale_q));
   assign sum_ext  = freq_ext + step_ext;
   assign diff_ext = freq_ext - step_ext;

   // Next frequency and scale; inc+dec together cancel, scale uses old step
   always_comb begin
      freq_d  = freq_q;
      scale_d = scale_q;
      if (press[1] && !press[2]) begin
         freq_d = (sum_ext > MAX_EXT) ? W'(MAX_EXT) : W'(sum_ext);
      end else if (press[2] && !press[1]) begin
         freq_d = (freq_ext < step_ext) ? '0 : W'(diff_ext);
      end
      if (press[3]) begin
         scale_d = scale_q + 2'd1;
      end
   end

   // Frequency and scale registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset_active) begin
         freq_q  <= W'(DEFAULT_FREQ);
         scale_q <= '0;
      end else begin
         freq_q  <= freq_d;
         scale_q <= scale_d;
      end
   end

   assign frequency_out = freq_q;

   // Decimal digits straight from the frequency register
   assign fbin     = 14'(freq_q);
   assign digit[3] = 4'((fbin / 14'd1000) % 14'd10);
   assign digit[2] = 4'((fbin / 14'd100) % 14'd10);
   assign digit[1] = 4'((fbin / 14'd10) % 14'd10);
   assign digit[0] = 4'(fbin % 14'd10);
   assign digit[4] = 4'(scale_q);

   for (genvar d = 0; d < 5; d++) begin : g_dec
      seven_seg_decoder u_dec (
         .digit_i (digit[d]),
         .seg_o   (seg[d])
      );
   end

   assign HEX0 = seg[0];
   assign HEX1 = seg[1];
   assign HEX2 = seg[2];
   assign HEX3 = seg[3];
   assign HEX4 = seg[4];
   assign HEX5 = SEG_BLANK;
   assign HEX6 = SEG_BLANK;
   assign HEX7 = SEG_BLANK;

endmodule
`default_nettype wire

// File: tb/tb_frequency_controller_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frequency_controller_top
//  Description : Directed, table-driven bench for frequency_controller_top.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frequency_controller_top;

   logic        clk = 1'b0;
   logic        key_0 = 1'b1, key_1 = 1'b1, key_2 = 1'b1, key_3 = 1'b1;
   logic        reset_active;
   logic [12:0] frequency_out;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] keys;    // {k3,k2,k1,k0}, 1 = pressed
      int         hold;
      int         exp_f;
      int         exp_s;
   } vec_t;

   vec_t vecs[$];

   frequency_controller_top #(.FREQUENCY_RANGE(8192), .W(13)) dut (
      .clk           (clk),
      .key_0         (key_0),
      .key_1         (key_1),
      .key_2         (key_2),
      .key_3         (key_3),
      .reset_active  (reset_active),
      .frequency_out (frequency_out),
      .HEX0          (HEX0),
      .HEX1          (HEX1),
      .HEX2          (HEX2),
      .HEX3          (HEX3),
      .HEX4          (HEX4),
      .HEX5          (HEX5),
      .HEX6          (HEX6),
      .HEX7          (HEX7)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input int f, input int s);
      logic [55:0] exp_hex, act_hex;
      exp_hex = {7'h7F, 7'h7F, 7'h7F, seg(s), seg((f / 1000) % 10),
                 seg((f / 100) % 10), seg((f / 10) % 10), seg(f % 10)};
      act_hex = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      chk({name, "_freq"}, 64'(frequency_out), 64'(f));
      chk({name, "_hex"}, 64'(act_hex), 64'(exp_hex));
      chk({name, "_rst"}, 64'(reset_active), 64'd0);
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      @(negedge clk);
      {key_3, key_2, key_1, key_0} = ~m;
      repeat (hold) @(negedge clk);
      {key_3, key_2, key_1, key_0} = 4'hF;
      repeat (8) @(negedge clk);
   endtask

   task automatic add(input logic [3:0] k, input int h, input int f, input int s);
      vec_t v;
      v.keys = k; v.hold = h; v.exp_f = f; v.exp_s = s;
      vecs.push_back(v);
   endtask

   initial begin
      // Reset, increments, scale change and a closing reset
      add(4'b0001, 5, 1000, 0);
      add(4'b0010, 5, 1001, 0);
      add(4'b0010, 5, 1002, 0);
      add(4'b0010, 5, 1003, 0);
      add(4'b1000, 5, 1003, 1);
      add(4'b0010, 5, 1013, 1);
      add(4'b0010, 5, 1023, 1);
      add(4'b0100, 5, 1013, 1);
      add(4'b0001, 5, 1000, 0);
      // Scale wrap 1,2,3,0
      add(4'b1000, 5, 1000, 1);
      add(4'b1000, 5, 1000, 2);
      add(4'b1000, 5, 1000, 3);
      add(4'b1000, 5, 1000, 0);
      // Climb to 7500 then saturate at 8191
      add(4'b1000, 5, 1000, 1);
      add(4'b1000, 5, 1000, 2);
      add(4'b1000, 5, 1000, 3);
      for (int i = 2; i <= 7; i++) add(4'b0010, 5, i * 1000, 3);
      add(4'b1000, 5, 7000, 0);
      add(4'b1000, 5, 7000, 1);
      add(4'b1000, 5, 7000, 2);
      for (int i = 1; i <= 5; i++) add(4'b0010, 5, 7000 + i * 100, 2);
      add(4'b1000, 5, 7500, 3);
      add(4'b0010, 5, 8191, 3);
      add(4'b0010, 5, 8191, 3);
      // Descend to 500 then clamp at 0
      add(4'b0001, 5, 1000, 0);
      add(4'b1000, 5, 1000, 1);
      add(4'b1000, 5, 1000, 2);
      for (int i = 1; i <= 5; i++) add(4'b0100, 5, 1000 - i * 100, 2);
      add(4'b1000, 5, 500, 3);
      add(4'b0100, 5, 0, 3);
      add(4'b0100, 5, 0, 3);
      // Long hold, simultaneous inc/dec, scale with increment, short press
      add(4'b0001, 5, 1000, 0);
      add(4'b0010, 100, 1001, 0);
      add(4'b0110, 5, 1001, 0);
      add(4'b1010, 5, 1002, 1);
      add(4'b0100, 5, 992, 1);
      add(4'b0010, 3, 1002, 1);

      repeat (3) @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         press(vecs[i].keys, vecs[i].hold);
         check_state($sformatf("vec%0d", i), vecs[i].exp_f, vecs[i].exp_s);
      end

      // Press-to-update latency: unchanged after 2 edges, updated by edge 4
      @(negedge clk);
      key_1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("lat_early", 64'(frequency_out), 64'd1002);
      repeat (2) @(negedge clk);
      chk("lat_done", 64'(frequency_out), 64'd1012);
      key_1 = 1'b1;
      repeat (8) @(negedge clk);

      // Reset latency and presses ignored during reset
      key_0 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_assert", 64'(reset_active), 64'd1);
      @(negedge clk);
      chk("rst_freq", 64'(frequency_out), 64'd1000);
      key_1 = 1'b0;
      repeat (4) @(negedge clk);
      key_1 = 1'b1;
      repeat (5) @(negedge clk);
      key_0 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_release", 64'(reset_active), 64'd0);
      repeat (8) @(negedge clk);
      check_state("rst_ignore", 1000, 0);

      // Key held through reset release produces no event until re-pressed
      key_0 = 1'b0;
      key_2 = 1'b0;
      repeat (6) @(negedge clk);
      key_0 = 1'b1;
      repeat (10) @(negedge clk);
      key_2 = 1'b1;
      repeat (8) @(negedge clk);
      check_state("held_thru", 1000, 0);
      press(4'b0100, 5);
      check_state("repress", 999, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
